// File: rtl/y86_bus_mem.sv
// y86_bus_mem
// -----------------------------------------------------------------------------
// This is the memory-side bus responder for the y86 sequential core.
//
// What it contains:
//   - A byte-addressed, little-endian RAM of 2^ADDR_W bytes.
//     Reads are combinational. Writes happen on the clock edge.
//   - A byte-wide loader port for preloading programs. A core write always
//     takes priority over the loader.
//   - A console register at the exact address CONS_ADDR.
//     Writes to it push bus_out[7:0] into a small FIFO.
//     The FIFO drains over a valid/ready handshake.
//     Reads of it return the status word {30'b0, con_ovf, fifo_full}.
//
// Optional build macro:
//   ACCESS_CNT_EN  Builds saturating counters of read and write bus accesses.
//                  When it is undefined, rd_cnt and wr_cnt are tied to zero.
//
// Ports:
//   clk, rst             Clock and asynchronous active-high reset.
//   bus_A                Byte address from the core.
//   bus_RE, bus_WE       Read strobe and write strobe.
//   bus_out              Write data from the core.
//   bus_in               Read data to the core (0 when bus_RE is low).
//   ld_valid, ld_ready   Loader handshake.
//   ld_addr, ld_data     Loader byte address and loader data byte.
//   con_valid, con_ready Console FIFO handshake.
//   con_data             FIFO head byte.
//   con_ovf              Sticky console overflow flag.
//   rd_cnt, wr_cnt       Access counters.
// -----------------------------------------------------------------------------
module y86_bus_mem #(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] CONS_ADDR  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       bus_A,
    input  logic              bus_RE,
    input  logic              bus_WE,
    input  logic [31:0]       bus_out,
    output logic [31:0]       bus_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              con_valid,
    input  logic              con_ready,
    output logic [7:0]        con_data,
    output logic              con_ovf,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
);

    localparam int MEM_SIZE = 1 << ADDR_W;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    logic [7:0] mem      [MEM_SIZE];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    // The FIFO pointers carry one extra bit, which tells full apart from empty.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           con_ovf_q, con_ovf_d;

    logic              cons_hit;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic [ADDR_W-1:0] a0, a1, a2, a3;

    // The byte lanes wrap naturally at ADDR_W bits.
    // As a result, a word at the top of RAM spills over into byte 0.
    assign a0 = bus_A[ADDR_W-1:0];
    assign a1 = a0 + ADDR_W'(1);
    assign a2 = a0 + ADDR_W'(2);
    assign a3 = a0 + ADDR_W'(3);

    assign cons_hit   = (bus_A == CONS_ADDR);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign pop      = !fifo_empty && con_ready;
    assign push_req = bus_WE && cons_hit;
    // A push into a full FIFO still succeeds when a pop frees a slot on the same edge.
    assign push_ok  = push_req && (!fifo_full || pop);

    assign ld_ready  = !bus_WE;
    assign con_valid = !fifo_empty;
    assign con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign con_ovf   = con_ovf_q;

    always_comb begin
        bus_in = '0;
        if (bus_RE) begin
            if (cons_hit) begin
                bus_in = {30'b0, con_ovf_q, fifo_full};
            end else begin
                bus_in = {mem[a3], mem[a2], mem[a1], mem[a0]};
            end
        end
    end

    // The RAM is not reset. The loader only writes when no core write is present.
    always_ff @(posedge clk) begin
        if (bus_WE && !cons_hit) begin
            mem[a0] <= bus_out[7:0];
            mem[a1] <= bus_out[15:8];
            mem[a2] <= bus_out[23:16];
            mem[a3] <= bus_out[31:24];
        end else if (ld_valid && ld_ready) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus_out[7:0];
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        con_ovf_d = con_ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
        if (push_req && fifo_full && !pop) begin
            con_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            con_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            con_ovf_q <= con_ovf_d;
        end
    end

`ifdef ACCESS_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Both counters saturate instead of wrapping. Console writes count as writes.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (bus_RE && (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (bus_WE && (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_y86_bus_mem.sv
// Testbench for y86_bus_mem.
// The bench has three phases:
//   1. A directed table of vectors with hand-derived expectations.
//   2. Several hand-written console and reset sequences.
//   3. A full RAM preload through the loader, followed by randomized traffic.
//      This traffic is checked against a byte-array plus queue reference model.
module tb_y86_bus_mem;

    localparam int          ADDR_W = 12;
    localparam int          MSZ    = 4096;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] CONS   = 32'hFFFF_FF00;
    localparam logic [31:0] ALL    = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic [31:0] bus_A;
    logic        bus_RE;
    logic        bus_WE;
    logic [31:0] bus_out;
    logic [31:0] bus_in;
    logic        ld_valid;
    logic        ld_ready;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data;
    logic        con_valid;
    logic        con_ready;
    logic [7:0]  con_data;
    logic        con_ovf;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    y86_bus_mem #(.ADDR_W(ADDR_W), .CONS_ADDR(CONS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE),
        .bus_out(bus_out), .bus_in(bus_in), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data), .con_valid(con_valid),
        .con_ready(con_ready), .con_data(con_data), .con_ovf(con_ovf),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    // The clock period is 10 time units. Rising edges occur at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        ldv;
        logic [11:0] lda;
        logic [7:0]  ldd;
        logic        cr;
        logic [31:0] exp_in;
        logic [31:0] mask;
        logic        exp_ldr;
        logic        exp_cv;
        logic [7:0]  exp_cd;
        logic        exp_ovf;
    } vec_t;

    int checksTotal  = 0;
    int checksPassed = 0;

    // Reference model state.
    logic [7:0]  refMem [MSZ];
    logic [7:0]  refQ [$];
    logic        refOvf;
    logic [31:0] refRd;
    logic [31:0] refWr;

    vec_t tbl [$];

    function automatic vec_t mk(input logic re, input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic ldv, input logic [11:0] lda,
                                input logic [7:0] ldd, input logic cr, input logic [31:0] exp_in,
                                input logic [31:0] mask, input logic exp_ldr, input logic exp_cv,
                                input logic [7:0] exp_cd, input logic exp_ovf);
        vec_t v;
        v.re = re;
        v.we = we;
        v.a = a;
        v.d = d;
        v.ldv = ldv;
        v.lda = lda;
        v.ldd = ldd;
        v.cr = cr;
        v.exp_in = exp_in;
        v.mask = mask;
        v.exp_ldr = exp_ldr;
        v.exp_cv = exp_cv;
        v.exp_cd = exp_cd;
        v.exp_ovf = exp_ovf;
        return v;
    endfunction

    function automatic vec_t idleVec();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp, input logic [31:0] mask);
        checksTotal++;
        if ((act & mask) === (exp & mask)) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (mask %h) at %0t",
                     name, act, exp, mask, $time);
        end
    endtask

    // The model reads a little-endian word with every byte index taken modulo the RAM size.
    function automatic logic [31:0] expBusIn(input logic re, input logic [31:0] a);
        int base;
        if (!re) return 32'h0;
        if (a == CONS) return {30'b0, refOvf, refQ.size() == DEPTH};
        base = int'(a[11:0]);
        return {refMem[(base + 3) % MSZ], refMem[(base + 2) % MSZ],
                refMem[(base + 1) % MSZ], refMem[base]};
    endfunction

    task automatic modelReset();
        refQ.delete();
        refOvf = 1'b0;
        refRd  = '0;
        refWr  = '0;
    endtask

    task automatic modelUpdate(input vec_t v);
        bit doPop;
        bit doPush;
        doPop  = (refQ.size() != 0) && v.cr;
        doPush = v.we && (v.a == CONS);
        if (doPop) void'(refQ.pop_front());
        if (doPush) begin
            if (refQ.size() == DEPTH) refOvf = 1'b1;
            else refQ.push_back(v.d[7:0]);
        end
        if (v.we && v.a != CONS) begin
            for (int k = 0; k < 4; k++) refMem[(int'(v.a[11:0]) + k) % MSZ] = v.d[8*k +: 8];
        end else if (v.ldv && !v.we) begin
            refMem[v.lda] = v.ldd;
        end
`ifdef ACCESS_CNT_EN
        if (v.re && refRd != 32'hFFFF_FFFF) refRd = refRd + 1;
        if (v.we && refWr != 32'hFFFF_FFFF) refWr = refWr + 1;
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        bus_RE    = v.re;
        bus_WE    = v.we;
        bus_A     = v.a;
        bus_out   = v.d;
        ld_valid  = v.ldv;
        ld_addr   = v.lda;
        ld_data   = v.ldd;
        con_ready = v.cr;
    endtask

    task automatic checkOutput(input vec_t v, input bit useTable);
        if (useTable) begin
            checkVal("tbl_bus_in", bus_in, v.exp_in, v.mask);
            checkVal("tbl_ld_ready", 32'(ld_ready), 32'(v.exp_ldr), ALL);
            checkVal("tbl_con_valid", 32'(con_valid), 32'(v.exp_cv), ALL);
            if (v.exp_cv) checkVal("tbl_con_data", 32'(con_data), 32'(v.exp_cd), ALL);
            checkVal("tbl_con_ovf", 32'(con_ovf), 32'(v.exp_ovf), ALL);
        end else begin
            checkVal("bus_in", bus_in, expBusIn(v.re, v.a), ALL);
            checkVal("ld_ready", 32'(ld_ready), 32'(!v.we), ALL);
            checkVal("con_valid", 32'(con_valid), 32'(refQ.size() != 0), ALL);
            if (refQ.size() != 0) checkVal("con_data", 32'(con_data), 32'(refQ[0]), ALL);
            checkVal("con_ovf", 32'(con_ovf), 32'(refOvf), ALL);
            checkVal("rd_cnt", rd_cnt, refRd, ALL);
            checkVal("wr_cnt", wr_cnt, refWr, ALL);
        end
    endtask

    // Each cycle is entered 1 time unit after a rising edge.
    // Outputs are sampled mid-cycle. The model then advances on the edge.
    task automatic runCycle(input vec_t v, input bit useTable);
        applyStimulus(v);
        #3;
        checkOutput(v, useTable);
        @(posedge clk);
        modelUpdate(v);
        #1;
    endtask

    task automatic syncReset();
        applyStimulus(idleVec());
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // This task asserts reset between edges.
    // The outputs must clear before any clock edge arrives.
    task automatic asyncResetCheck();
        applyStimulus(idleVec());
        #3;
        rst = 1'b1;
        #1;
        checkVal("async_con_valid", 32'(con_valid), 32'h0, ALL);
        checkVal("async_con_data", 32'(con_data), 32'h0, ALL);
        checkVal("async_con_ovf", 32'(con_ovf), 32'h0, ALL);
        checkVal("async_rd_cnt", rd_cnt, 32'h0, ALL);
        checkVal("async_wr_cnt", wr_cnt, 32'h0, ALL);
        checkVal("async_ld_ready", 32'(ld_ready), 32'h1, ALL);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0, 1:    return CONS;
            2:       return CONS + 32'($urandom_range(1, 3));
            3:       return {r[31:12], 12'hFFC + 12'($urandom_range(0, 3))};
            default: return r;
        endcase
    endfunction

    logic [7:0] drainExp [4];

    initial begin
        vec_t v;
        rst = 1'b1;
        applyStimulus(idleVec());
        modelReset();
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // The directed table starts from a fresh reset.
        tbl.push_back(mk(0, 0, 0, 0, 1, 12'd0, 8'h30, 0, 0, ALL, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 12'd1, 8'hF0, 0, 0, ALL, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 12'd2, 8'h05, 0, 0, ALL, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 12'd3, 8'h00, 0, 0, ALL, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0005F030, ALL, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8, 32'hDEADBEEF, 1, 12'd20, 8'h77, 0, 0, ALL, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 9, 0, 1, 12'd20, 8'h77, 0, 32'h00DEADBE, 32'h00FFFFFF, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 20, 0, 0, 0, 0, 0, 32'h00000077, 32'h000000FF, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8, 0, 0, 0, 0, 0, 32'hDEADBEEF, ALL, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'hFFF, 32'h11223344, 0, 0, 0, 0, 32'h05F03000, 32'hFFFFFF00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h12345FFF, 0, 0, 0, 0, 0, 32'h11223344, ALL, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h00112233, ALL, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, CONS, 32'h61, 0, 0, 0, 0, 0, ALL, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, CONS, 32'h62, 0, 0, 0, 0, 0, ALL, 0, 1, 8'h61, 0));
        tbl.push_back(mk(0, 1, CONS, 32'h63, 0, 0, 0, 0, 0, ALL, 0, 1, 8'h61, 0));
        tbl.push_back(mk(0, 1, CONS, 32'h64, 0, 0, 0, 0, 0, ALL, 0, 1, 8'h61, 0));
        tbl.push_back(mk(0, 1, CONS, 32'h65, 0, 0, 0, 0, 0, ALL, 0, 1, 8'h61, 0));
        tbl.push_back(mk(1, 0, CONS, 0, 0, 0, 0, 0, 32'h3, ALL, 1, 1, 8'h61, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, ALL, 1, 1, 8'h61, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, ALL, 1, 1, 8'h62, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, ALL, 1, 1, 8'h63, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, ALL, 1, 1, 8'h64, 1));
        tbl.push_back(mk(1, 0, CONS, 0, 0, 0, 0, 0, 32'h2, ALL, 1, 0, 8'h00, 1));
        foreach (tbl[i]) runCycle(tbl[i], 1'b1);

        // Sequence: a push and a pop on the same edge while full must not overflow.
        syncReset();
        for (int i = 0; i < 4; i++) runCycle(mk(0, 1, CONS, 32'h61 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        runCycle(mk(0, 1, CONS, 32'h78, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        checkVal("full_pushpop_ovf", 32'(con_ovf), 32'h0, ALL);
        runCycle(mk(1, 0, CONS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        checkVal("full_pushpop_status", bus_in, 32'h1, ALL);
        drainExp[0] = 8'h62;
        drainExp[1] = 8'h63;
        drainExp[2] = 8'h64;
        drainExp[3] = 8'h78;
        for (int i = 0; i < 4; i++) begin
            checkVal("drain_data", 32'(con_data), 32'(drainExp[i]), ALL);
            runCycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        end
        checkVal("drain_empty", 32'(con_valid), 32'h0, ALL);

        // Sequence: a push and a pop on the same edge while empty leaves one byte queued.
        syncReset();
        runCycle(mk(0, 1, CONS, 32'h7A, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        checkVal("empty_pushpop_valid", 32'(con_valid), 32'h1, ALL);
        checkVal("empty_pushpop_data", 32'(con_data), 32'h7A, ALL);

        // Sequence: 3 reads and 2 writes, then an asynchronous reset mid-stream.
        syncReset();
        runCycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        runCycle(mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        runCycle(mk(0, 1, 100, 32'hCAFE0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        runCycle(mk(1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        runCycle(mk(0, 1, CONS, 32'h41, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
`ifdef ACCESS_CNT_EN
        checkVal("cnt_rd", rd_cnt, 32'd3, ALL);
        checkVal("cnt_wr", wr_cnt, 32'd2, ALL);
`else
        checkVal("cnt_rd_tied", rd_cnt, 32'd0, ALL);
        checkVal("cnt_wr_tied", wr_cnt, 32'd0, ALL);
`endif
        checkVal("pre_reset_valid", 32'(con_valid), 32'h1, ALL);
        asyncResetCheck();

        // Preload the whole RAM through the loader so that every model byte is known.
        for (int i = 0; i < MSZ; i++) begin
            runCycle(mk(0, 0, 0, 0, 1, 12'(i), 8'($urandom), 0, 0, 0, 0, 0, 0, 0), 1'b0);
        end

        // Randomized traffic, with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                asyncResetCheck();
            end else begin
                v = mk($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, randAddr(), $urandom,
                       $urandom_range(0, 1) == 1, 12'($urandom), 8'($urandom),
                       $urandom_range(0, 3) == 0, 0, 0, 0, 0, 0, 0);
                runCycle(v, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
